// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative 32-step shift-add unsigned
// multiplier, write-back register select and the EX/MEM pipeline register.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_1_in,
   input  logic [31:0] data_2_in,
   input  logic [31:0] sign_imm_in,
   input  logic [4:0]  shamt_in,
   input  logic [4:0]  rt_in,
   input  logic [4:0]  rd_in,
   input  logic        reg_wen_in,
   input  logic        reg_des_in,
   input  logic        dmem_alu_in,
   input  logic        mem_wen_in,
   input  logic        alu_sel_in,
   input  logic [4:0]  alu_code_in,
   input  logic [31:0] pc_in,
   output logic [31:0] alu_result_out,
   output logic [31:0] store_data_out,
   output logic [4:0]  wr_reg_out,
   output logic        reg_wen_out,
   output logic        dmem_alu_out,
   output logic        mem_wen_out,
   output logic [31:0] pc_out,
   output logic        stall_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_NOR   = 5'd5;
   localparam logic [4:0] OP_SLT   = 5'd6;
   localparam logic [4:0] OP_SLTU  = 5'd7;
   localparam logic [4:0] OP_SLL   = 5'd8;
   localparam logic [4:0] OP_SRL   = 5'd9;
   localparam logic [4:0] OP_SRA   = 5'd10;
   localparam logic [4:0] OP_LUI   = 5'd11;
   localparam logic [4:0] OP_MUL   = 5'd12;
   localparam logic [4:0] OP_MULHU = 5'd13;

   state_t      state_reg;
   logic [4:0]  count_reg;
   logic [63:0] mcand_reg;   // multiplicand, shifted left one place per step
   logic [31:0] mplier_reg;  // multiplier, consumed LSB first
   logic [63:0] acc_reg;     // running partial product

   logic [31:0] op_b;
   logic        is_mul;
   logic [31:0] alu_result;
   logic [31:0] mul_result;
   logic [31:0] final_result;

   assign op_b      = alu_sel_in ? sign_imm_in : data_2_in;
   assign is_mul    = (alu_code_in == OP_MUL) || (alu_code_in == OP_MULHU);
   assign stall_out = ((state_reg == IDLE) && is_mul) || (state_reg == BUSY);

   // Single-cycle ALU operations; multiply codes and unused codes yield 0 here
   always_comb begin
      alu_result = 32'd0;
      case (alu_code_in)
         OP_ADD:  alu_result = data_1_in + op_b;
         OP_SUB:  alu_result = data_1_in - op_b;
         OP_AND:  alu_result = data_1_in & op_b;
         OP_OR:   alu_result = data_1_in | op_b;
         OP_XOR:  alu_result = data_1_in ^ op_b;
         OP_NOR:  alu_result = ~(data_1_in | op_b);
         OP_SLT:  alu_result = {31'd0, ($signed(data_1_in) < $signed(op_b))};
         OP_SLTU: alu_result = {31'd0, (data_1_in < op_b)};
         OP_SLL:  alu_result = op_b << shamt_in;
         OP_SRL:  alu_result = op_b >> shamt_in;
         OP_SRA:  alu_result = $signed(op_b) >>> shamt_in;
         OP_LUI:  alu_result = {op_b[15:0], 16'h0000};
         default: alu_result = 32'd0;
      endcase
   end

   // Product half selection uses the instruction still held on the inputs
   always_comb begin
      mul_result   = (alu_code_in == OP_MULHU) ? acc_reg[63:32] : acc_reg[31:0];
      final_result = (state_reg == DONE) ? mul_result : alu_result;
   end

   // Multiplier control: latch operands, 32 shift-add steps, one DONE cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= 5'd0;
         mcand_reg  <= 64'd0;
         mplier_reg <= 32'd0;
         acc_reg    <= 64'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (is_mul) begin
                  mcand_reg  <= {32'd0, data_1_in};
                  mplier_reg <= op_b;
                  acc_reg    <= 64'd0;
                  count_reg  <= 5'd0;
                  state_reg  <= BUSY;
               end
            end
            BUSY: begin
               if (mplier_reg[0]) begin
                  acc_reg <= acc_reg + mcand_reg;
               end
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               count_reg  <= count_reg + 5'd1;
               if (count_reg == 5'd31) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // Always return to IDLE so the held instruction is not re-issued
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // EX/MEM register: bubble while stalled, otherwise capture result and fields
   always_ff @(posedge clk) begin
      if (rst || stall_out) begin
         alu_result_out <= 32'd0;
         store_data_out <= 32'd0;
         wr_reg_out     <= 5'd0;
         reg_wen_out    <= 1'b0;
         dmem_alu_out   <= 1'b0;
         mem_wen_out    <= 1'b0;
         pc_out         <= 32'd0;
      end else begin
         alu_result_out <= final_result;
         store_data_out <= data_2_in;
         wr_reg_out     <= reg_des_in ? rd_in : rt_in;
         reg_wen_out    <= reg_wen_in;
         dmem_alu_out   <= dmem_alu_in;
         mem_wen_out    <= mem_wen_in;
         pc_out         <= pc_in;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_1_in, data_2_in, sign_imm_in, pc_in;
   logic [4:0]  shamt_in, rt_in, rd_in, alu_code_in;
   logic        reg_wen_in, reg_des_in, dmem_alu_in, mem_wen_in, alu_sel_in;
   logic [31:0] alu_result_out, store_data_out, pc_out;
   logic [4:0]  wr_reg_out;
   logic        reg_wen_out, dmem_alu_out, mem_wen_out, stall_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk            (clk),
      .rst            (rst),
      .data_1_in      (data_1_in),
      .data_2_in      (data_2_in),
      .sign_imm_in    (sign_imm_in),
      .shamt_in       (shamt_in),
      .rt_in          (rt_in),
      .rd_in          (rd_in),
      .reg_wen_in     (reg_wen_in),
      .reg_des_in     (reg_des_in),
      .dmem_alu_in    (dmem_alu_in),
      .mem_wen_in     (mem_wen_in),
      .alu_sel_in     (alu_sel_in),
      .alu_code_in    (alu_code_in),
      .pc_in          (pc_in),
      .alu_result_out (alu_result_out),
      .store_data_out (store_data_out),
      .wr_reg_out     (wr_reg_out),
      .reg_wen_out    (reg_wen_out),
      .dmem_alu_out   (dmem_alu_out),
      .mem_wen_out    (mem_wen_out),
      .pc_out         (pc_out),
      .stall_out      (stall_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: results derived directly from the operation definitions
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic [4:0] code);
      logic [63:0] prod;
      logic [31:0] fill;
      prod = 64'(a) * 64'(b);
      fill = (b[31]) ? ~(32'hFFFFFFFF >> sh) : 32'd0;
      case (code)
         5'd0:    return a + b;
         5'd1:    return a - b;
         5'd2:    return a & b;
         5'd3:    return a | b;
         5'd4:    return a ^ b;
         5'd5:    return ~(a | b);
         5'd6:    return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         5'd7:    return {31'd0, (a < b)};
         5'd8:    return b << sh;
         5'd9:    return b >> sh;
         5'd10:   return (b >> sh) | fill;
         5'd11:   return b * 32'd65536;
         5'd12:   return prod[31:0];
         5'd13:   return prod[63:32];
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                        input logic [4:0] sh, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] code, input logic sel, input logic des,
                        input logic wen, input logic dmem, input logic mwen,
                        input logic [31:0] pc);
      data_1_in   = a;
      data_2_in   = b2;
      sign_imm_in = imm;
      shamt_in    = sh;
      rt_in       = rt;
      rd_in       = rd;
      alu_code_in = code;
      alu_sel_in  = sel;
      reg_des_in  = des;
      reg_wen_in  = wen;
      dmem_alu_in = dmem;
      mem_wen_in  = mwen;
      pc_in       = pc;
   endtask

   // One transaction; entered and left 1 time unit after a rising edge
   task automatic do_op(input string name,
                        input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                        input logic [4:0] sh, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] code, input logic sel, input logic des,
                        input logic wen, input logic dmem, input logic mwen,
                        input logic [31:0] pc);
      logic [31:0] exp;
      bit          mul;
      int          n;
      drive(a, b2, imm, sh, rt, rd, code, sel, des, wen, dmem, mwen, pc);
      exp = ref_alu(a, sel ? imm : b2, sh, code);
      mul = (code == 5'd12) || (code == 5'd13);
      #1;
      chk({name, "_stall_start"}, 32'(stall_out), 32'(mul));
      n = 0;
      while (stall_out && n < 40) begin
         n++;
         @(posedge clk);
         #1;
         chk({name, "_bubble_res"}, alu_result_out, 32'd0);
         chk({name, "_bubble_wen"}, 32'(reg_wen_out), 32'd0);
      end
      if (mul) chk({name, "_stall_cycles"}, n, 33);
      @(posedge clk);
      #1;
      chk({name, "_result"}, alu_result_out, exp);
      chk({name, "_store"}, store_data_out, b2);
      chk({name, "_wr_reg"}, 32'(wr_reg_out), 32'(des ? rd : rt));
      chk({name, "_reg_wen"}, 32'(reg_wen_out), 32'(wen));
      chk({name, "_dmem_alu"}, 32'(dmem_alu_out), 32'(dmem));
      chk({name, "_mem_wen"}, 32'(mem_wen_out), 32'(mwen));
      chk({name, "_pc"}, pc_out, pc);
      $display("op %-8s code=%0d a=%h b=%h result=%h expected=%h stall_cycles=%0d",
               name, code, a, sel ? imm : b2, alu_result_out, exp, n);
   endtask

   initial begin
      logic [4:0] rc;
      // Reset with random, non-multiply inputs
      rst = 1'b1;
      rc = 5'($urandom_range(0, 11));
      drive($urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
            rc, 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1, $urandom);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", alu_result_out, 32'd0);
      chk("rst_store", store_data_out, 32'd0);
      chk("rst_wr_reg", 32'(wr_reg_out), 32'd0);
      chk("rst_ctrl", {29'd0, reg_wen_out, dmem_alu_out, mem_wen_out}, 32'd0);
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_stall", 32'(stall_out), 32'd0);
      rst = 1'b0;
      do_op("zero", 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0);

      // Directed cases
      do_op("add_rd",  32'hFFFFFFFF, 2, 0, 0, 3, 7, 5'd0, 0, 1, 1, 0, 0, 32'h100);
      do_op("add_rt",  32'hFFFFFFFF, 2, 0, 0, 3, 7, 5'd0, 0, 0, 1, 0, 0, 32'h104);
      do_op("sra",     0, 32'h80000000, 0, 4, 1, 2, 5'd10, 0, 1, 1, 0, 0, 32'h108);
      do_op("srl",     0, 32'h80000000, 0, 4, 1, 2, 5'd9,  0, 1, 1, 0, 0, 32'h10C);
      do_op("slt",     32'hFFFFFFFF, 1, 0, 0, 1, 2, 5'd6, 0, 1, 1, 0, 0, 32'h110);
      do_op("sltu",    32'hFFFFFFFF, 1, 0, 0, 1, 2, 5'd7, 0, 1, 1, 0, 0, 32'h114);
      do_op("lui",     0, 32'hDEAD, 32'h00001234, 0, 5, 6, 5'd11, 1, 0, 1, 0, 0, 32'h118);
      do_op("mul",     32'h12345678, 32'h10, 0, 0, 1, 9, 5'd12, 0, 1, 1, 0, 0, 32'h11C);
      do_op("mulhu",   32'h12345678, 32'h10, 0, 0, 1, 9, 5'd13, 0, 1, 1, 0, 0, 32'h120);
      do_op("mul_ff",  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 9, 5'd12, 0, 1, 1, 0, 0, 32'h124);
      do_op("mulhu_ff",32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 9, 5'd13, 0, 1, 1, 0, 0, 32'h128);
      do_op("add_b2b", 32'd40, 32'd2, 0, 0, 4, 8, 5'd0, 0, 1, 1, 0, 0, 32'h12C);
      do_op("code20",  32'h55, 32'hCAFEF00D, 0, 0, 4, 8, 5'd20, 0, 0, 0, 1, 1, 32'h130);

      // Reset in the middle of a multiply
      drive(32'h7, 32'h9, 0, 0, 1, 2, 5'd12, 0, 1, 1, 0, 0, 32'h200);
      repeat (10) @(posedge clk);
      #1;
      chk("mid_busy_stall", 32'(stall_out), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_result", alu_result_out, 32'd0);
      chk("mid_rst_pc", pc_out, 32'd0);
      chk("mid_rst_idle", 32'(stall_out), 32'd1);
      do_op("add_post", 32'd100, 32'd23, 0, 0, 3, 4, 5'd0, 0, 1, 1, 0, 0, 32'h204);

      // Randomized operations, multiplies included
      for (int i = 0; i < 150; i++) begin
         do_op("rand", $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
